pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register ids, sequencer state,
// and the bundle of per-stage enable/flush controls.
package pipe_hazard_ctrl_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } pipe_ctrl_t;

   // A load in ID/EX feeding either source of the instruction in IF/ID; r0 never hazards.
   function automatic logic load_use(input logic mem_to_reg, input regbits_t rd,
                                     input regbits_t rs, input regbits_t rt);
      return mem_to_reg && (rd != 5'd0) && ((rd == rs) || (rd == rt));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns cache handshakes, load-use, EX redirects and halt into
// per-register enable/flush plus PC enable, and drains the pipe on halt.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_req,
   input  logic             idex_memToReg,
   input  regbits_t         idex_rd,
   input  regbits_t         ifid_rs,
   input  regbits_t         ifid_rt,
   input  logic             redirect_ex,
   input  logic             halt_id,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pipe_state_t state;
   logic        ipend;
   logic        mem_ok;
   logic        fetch_ok;
   logic        lu;
   logic        fsm_upd;
   pipe_ctrl_t  ctrl;

   assign mem_ok   = !mem_req || dhit;
   assign fetch_ok = ihit || ipend || (state != RUN);
   assign lu       = load_use(idex_memToReg, idex_rd, ifid_rs, ifid_rt);

   always_comb begin
      ctrl    = '0;
      fsm_upd = 1'b0;
      if (state == HALTED) begin
         ctrl = '0;
      end else if (!mem_ok) begin
         ctrl = '0;
      end else if (!fetch_ok) begin
         // Front end starved: let the back half drain and insert a bubble into EX/MEM.
         ctrl.exmem_en    = 1'b1;
         ctrl.memwb_en    = 1'b1;
         ctrl.exmem_flush = 1'b1;
      end else begin
         fsm_upd       = 1'b1;
         ctrl.exmem_en = 1'b1;
         ctrl.memwb_en = 1'b1;
         ctrl.idex_en  = 1'b1;
         if (redirect_ex) begin
            ctrl.ifid_en    = 1'b1;
            ctrl.pc_en      = 1'b1;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
         end else if (lu) begin
            ctrl.idex_flush = 1'b1;
         end else begin
            ctrl.ifid_en = 1'b1;
            ctrl.pc_en   = (state == RUN);
         end
      end
      if ((state == DRAIN) && ctrl.ifid_en) begin
         ctrl.ifid_flush = 1'b1;
      end
      if (!nRST) begin
         ctrl = '0;
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_flush = ctrl.exmem_flush;
   assign memwb_flush = ctrl.memwb_flush;
   assign halt        = (state == HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
      end else if (halt_wb) begin
         state <= HALTED;
      end else if (fsm_upd) begin
         case (state)
            RUN:     if (halt_id && !lu && !redirect_ex) state <= DRAIN;
            DRAIN:   if (redirect_ex) state <= RUN;
            default: state <= state;
         endcase
      end
   end

   // Remember an instruction return that arrived while the D-side froze the pipe.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ipend <= 1'b0;
      end else if (ctrl.ifid_en) begin
         ipend <= 1'b0;
      end else if (ihit && !mem_ok) begin
         ipend <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .en    ((state == RUN) && !ctrl.pc_en),
      .clr   (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .en    (ctrl.ifid_flush || ctrl.idex_flush),
      .clr   (1'b0),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized stimulus for pipe_hazard_ctrl, checked against a rule-table
// model of the sequencer with narrow counters so saturation is reachable.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int CNT_W = 4;
   localparam int SAT   = 15;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             ihit = 1'b0, dhit = 1'b0, mem_req = 1'b0, idex_memToReg = 1'b0;
   regbits_t         idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
   logic             redirect_ex = 1'b0, halt_id = 1'b0, halt_wb = 1'b0;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .idex_memToReg(idex_memToReg), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
      .ifid_rt(ifid_rt), .redirect_ex(redirect_ex), .halt_id(halt_id), .halt_wb(halt_wb),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   // Reference model: 0=running, 1=draining, 2=halted
   int m_state = 0;
   bit m_ipend = 0;
   int m_stall = 0;
   int m_flush = 0;
   int n_total = 0;
   int n_pass  = 0;
   int n_step  = 0;

   // Output pattern per winning rule:
   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_f, idex_f, exmem_f, memwb_f, halt}
   function automatic logic [9:0] pattern(input int rule, input int st);
      case (rule)
         1: return 10'b0000000001;
         2: return 10'b0000000000;
         3: return 10'b0001100100;
         4: return 10'b1111111000;
         5: return 10'b0011101000;
         default: return (st == 1) ? 10'b0111110000 : 10'b1111100000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s step=%0d observed=%h expected=%h", tag, n_step, obs, exp);
   endtask

   task automatic step(input bit rst, input bit ih, input bit dh, input bit mr, input bit m2r,
                       input int rd, input int rs, input int rt,
                       input bit rdr, input bit hid, input bit hwb);
      bit         mem_ok, fetch_ok, is_lu;
      int         rule;
      logic [9:0] exp_v, obs_v;
      @(negedge CLK);
      nRST = ~rst; ihit = ih; dhit = dh; mem_req = mr; idex_memToReg = m2r;
      idex_rd = 5'(rd); ifid_rs = 5'(rs); ifid_rt = 5'(rt);
      redirect_ex = rdr; halt_id = hid; halt_wb = hwb;
      if (rst) begin
         m_state = 0; m_ipend = 0; m_stall = 0; m_flush = 0;
      end
      #1;
      n_step++;
      mem_ok   = !mr || dh;
      fetch_ok = ih || m_ipend || (m_state != 0);
      is_lu    = m2r && (rd != 0) && (rd == rs || rd == rt);
      if (m_state == 2)   rule = 1;
      else if (!mem_ok)   rule = 2;
      else if (!fetch_ok) rule = 3;
      else if (rdr)       rule = 4;
      else if (is_lu)     rule = 5;
      else                rule = 6;
      exp_v = rst ? 10'b0 : pattern(rule, m_state);
      obs_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
      check("ctrl", 32'(obs_v), 32'(exp_v));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      $display("step %0d rst=%0b rule=%0d ctrl=%b stall=%0d flush=%0d", n_step, rst, rule,
               obs_v, stall_cnt, flush_cnt);
      @(posedge CLK);
      if (!rst) begin
         if (m_state == 0 && !exp_v[9] && m_stall < SAT) m_stall++;
         if ((exp_v[4] || exp_v[3]) && m_flush < SAT) m_flush++;
         if (exp_v[8])                m_ipend = 0;
         else if (ih && !mem_ok)      m_ipend = 1;
         if (rule >= 4) begin
            if (m_state == 0 && hid && !is_lu && !rdr) m_state = 1;
            else if (m_state == 1 && rdr)               m_state = 0;
         end
         if (hwb) m_state = 2;
      end
   endtask

   initial begin
      // reset state
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      // clean streaming
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      // load-use on rs, then on rt, then r0 (no hazard)
      step(0, 1, 0, 0, 1, 5, 5, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 7, 1, 7, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // D-stall 4 cycles with ihit in cycle 2, then dhit releases using ipend
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // ihit and dhit together with mem_req
      step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      // redirect beats load-use
      step(0, 1, 0, 0, 1, 3, 3, 3, 1, 0, 0);
      // halt_id -> drain, then squashed by redirect
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // halt_wb -> sticky halted
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      // saturation of stall counter, then reset mid-stall
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // flush counter saturation via repeated redirects
      for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 59) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
